vx_cache_req_rr_arb: RTL and testbench

//  Round-robin arbiter that merges NUM_INPUTS single-lane cache request streams into one cache request port.

---
 rtl/vx_cache_req_rr_arb_pkg.sv | 15 +
 rtl/vx_rr_arbiter.sv | 46 ++++
 rtl/vx_cache_req_rr_arb.sv | 107 ++++++++++
 tb/tb_vx_cache_req_rr_arb.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/vx_cache_req_rr_arb_pkg.sv
// Shared helpers for the cache request round-robin arbiter slice.
// Default widths and the modulo-N pointer increment used by the arbiter.
package vx_cache_req_rr_arb_pkg;

   localparam int DEF_NUM_INPUTS   = 4;
   localparam int DEF_DATA_WIDTH   = 32;
   localparam int DEF_ADDR_WIDTH   = 32;
   localparam int DEF_TAG_IN_WIDTH = 8;

   // Next round-robin start position; wraps explicitly so non-power-of-2 N never yields N.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin grant logic: combinational search from the pointer, pointer advances past the
// winner only when the grant is actually consumed (enable && grant_valid).
module vx_rr_arbiter
   import vx_cache_req_rr_arb_pkg::*;
#(
   parameter int  NUM_REQS = DEF_NUM_INPUTS,
   localparam int SEL_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_REQS-1:0] requests,
   input  logic                enable,
   output logic [SEL_W-1:0]    grant_index,
   output logic [NUM_REQS-1:0] grant_onehot,
   output logic                grant_valid
);

   logic [SEL_W-1:0] ptr_reg;
   int unsigned      cand;

   always_comb begin
      grant_valid = 1'b0;
      grant_index = '0;
      cand        = 0;
      for (int k = 0; k < NUM_REQS; k++) begin
         cand = (int'(ptr_reg) + k) % NUM_REQS;
         if (!grant_valid && requests[cand]) begin
            grant_valid = 1'b1;
            grant_index = SEL_W'(cand);
         end
      end
   end

   for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_onehot
      assign grant_onehot[gi] = grant_valid && (grant_index == SEL_W'(gi));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_reg <= '0;
      end else if (enable && grant_valid) begin
         ptr_reg <= SEL_W'(rr_next(int'(grant_index), NUM_REQS));
      end
   end

endmodule

// File: rtl/vx_cache_req_rr_arb.sv
// Merges NUM_INPUTS cache request streams into one port through a single registered stage,
// tagging each request with the index of the input it came from.
module vx_cache_req_rr_arb
   import vx_cache_req_rr_arb_pkg::*;
#(
   parameter int  NUM_INPUTS    = DEF_NUM_INPUTS,
   parameter int  DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int  ADDR_WIDTH    = DEF_ADDR_WIDTH,
   parameter int  TAG_IN_WIDTH  = DEF_TAG_IN_WIDTH,
   parameter int  DATA_SIZE     = DATA_WIDTH / 8,
   localparam int SEL_WIDTH     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
   localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_WIDTH
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_INPUTS-1:0]              req_valid_in,
   input  logic [NUM_INPUTS-1:0]              req_rw_in,
   input  logic [NUM_INPUTS*DATA_SIZE-1:0]    req_byteen_in,
   input  logic [NUM_INPUTS*ADDR_WIDTH-1:0]   req_addr_in,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0]   req_data_in,
   input  logic [NUM_INPUTS*TAG_IN_WIDTH-1:0] req_tag_in,
   output logic [NUM_INPUTS-1:0]              req_ready_out,
   output logic                               req_valid_out,
   output logic                               req_rw_out,
   output logic [DATA_SIZE-1:0]               req_byteen_out,
   output logic [ADDR_WIDTH-1:0]              req_addr_out,
   output logic [DATA_WIDTH-1:0]              req_data_out,
   output logic [TAG_OUT_WIDTH-1:0]           req_tag_out,
   input  logic                               req_ready_in
);

   if (NUM_INPUTS < 2) begin : g_bad_num_inputs
      $error("vx_cache_req_rr_arb: NUM_INPUTS must be >= 2");
   end

   logic                    stage_en;
   logic [SEL_WIDTH-1:0]    grant_index;
   logic [NUM_INPUTS-1:0]   grant_onehot;
   logic                    grant_valid;

   logic                    rw_arr     [NUM_INPUTS];
   logic [DATA_SIZE-1:0]    byteen_arr [NUM_INPUTS];
   logic [ADDR_WIDTH-1:0]   addr_arr   [NUM_INPUTS];
   logic [DATA_WIDTH-1:0]   data_arr   [NUM_INPUTS];
   logic [TAG_IN_WIDTH-1:0] tag_arr    [NUM_INPUTS];

   logic                     valid_reg;
   logic                     rw_reg;
   logic [DATA_SIZE-1:0]     byteen_reg;
   logic [ADDR_WIDTH-1:0]    addr_reg;
   logic [DATA_WIDTH-1:0]    data_reg;
   logic [TAG_OUT_WIDTH-1:0] tag_reg;

   for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_unpack
      assign rw_arr[gi]     = req_rw_in[gi];
      assign byteen_arr[gi] = req_byteen_in[gi*DATA_SIZE +: DATA_SIZE];
      assign addr_arr[gi]   = req_addr_in[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_arr[gi]   = req_data_in[gi*DATA_WIDTH +: DATA_WIDTH];
      assign tag_arr[gi]    = req_tag_in[gi*TAG_IN_WIDTH +: TAG_IN_WIDTH];
   end

   // Stage frees up when empty or draining this cycle, so back-to-back accepts need no bubble.
   assign stage_en = !valid_reg || req_ready_in;

   vx_rr_arbiter #(
      .NUM_REQS (NUM_INPUTS)
   ) u_arb (
      .clk          (clk),
      .rst_n        (rst_n),
      .requests     (req_valid_in),
      .enable       (stage_en),
      .grant_index  (grant_index),
      .grant_onehot (grant_onehot),
      .grant_valid  (grant_valid)
   );

   // Gated by rst_n so no requester sees an accept while the stage is being cleared.
   assign req_ready_out = (stage_en && rst_n) ? grant_onehot : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_reg  <= 1'b0;
         rw_reg     <= 1'b0;
         byteen_reg <= '0;
         addr_reg   <= '0;
         data_reg   <= '0;
         tag_reg    <= '0;
      end else if (stage_en) begin
         valid_reg <= grant_valid;
         if (grant_valid) begin
            rw_reg     <= rw_arr[grant_index];
            byteen_reg <= byteen_arr[grant_index];
            addr_reg   <= addr_arr[grant_index];
            data_reg   <= data_arr[grant_index];
            tag_reg    <= {tag_arr[grant_index], grant_index};
         end
      end
   end

   assign req_valid_out  = valid_reg;
   assign req_rw_out     = rw_reg;
   assign req_byteen_out = byteen_reg;
   assign req_addr_out   = addr_reg;
   assign req_data_out   = data_reg;
   assign req_tag_out    = tag_reg;

endmodule

// File: tb/tb_vx_cache_req_rr_arb.sv
// Directed + randomized bench for the round-robin cache request arbiter (N=4 scoreboarded, N=3 grant order).
module tb_vx_cache_req_rr_arb;

   typedef struct packed {
      logic        rw;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] data;
      logic [9:0]  tag;
   } tx_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   valid_in;
   logic [3:0]   ready_out;
   logic         ready_in;
   logic [3:0]   rw_bus;
   logic [15:0]  be_bus;
   logic [127:0] addr_bus, data_bus;
   logic [31:0]  tag_bus;
   logic         valid_out, rw_out;
   logic [3:0]   be_out;
   logic [31:0]  addr_out, data_out;
   logic [9:0]   tag_out;

   logic         rw_a   [4];
   logic [3:0]   be_a   [4];
   logic [31:0]  addr_a [4];
   logic [31:0]  data_a [4];
   logic [7:0]   tag_a  [4];

   logic [2:0]   valid3, ready3_out;
   logic         ready3_in, valid3_out, rw3_out;
   logic [3:0]   be3_out;
   logic [31:0]  addr3_out, data3_out;
   logic [9:0]   tag3_out;

   tx_t q[$];
   int  mptr = 0;
   int  errors = 0;
   int  checks = 0;

   always #5 clk = ~clk;

   always_comb begin
      rw_bus = '0; be_bus = '0; addr_bus = '0; data_bus = '0; tag_bus = '0;
      for (int i = 0; i < 4; i++) begin
         rw_bus[i]          = rw_a[i];
         be_bus[i*4 +: 4]   = be_a[i];
         addr_bus[i*32 +: 32] = addr_a[i];
         data_bus[i*32 +: 32] = data_a[i];
         tag_bus[i*8 +: 8]  = tag_a[i];
      end
   end

   vx_cache_req_rr_arb dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_in(valid_in), .req_rw_in(rw_bus), .req_byteen_in(be_bus),
      .req_addr_in(addr_bus), .req_data_in(data_bus), .req_tag_in(tag_bus),
      .req_ready_out(ready_out), .req_valid_out(valid_out), .req_rw_out(rw_out),
      .req_byteen_out(be_out), .req_addr_out(addr_out), .req_data_out(data_out),
      .req_tag_out(tag_out), .req_ready_in(ready_in)
   );

   vx_cache_req_rr_arb #(.NUM_INPUTS(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_valid_in(valid3), .req_rw_in(3'b010), .req_byteen_in(12'hFA5),
      .req_addr_in({32'h3000, 32'h2000, 32'h1000}), .req_data_in({32'hC, 32'hB, 32'hA}),
      .req_tag_in({8'h12, 8'h11, 8'h10}),
      .req_ready_out(ready3_out), .req_valid_out(valid3_out), .req_rw_out(rw3_out),
      .req_byteen_out(be3_out), .req_addr_out(addr3_out), .req_data_out(data3_out),
      .req_tag_out(tag3_out), .req_ready_in(ready3_in)
   );

   task automatic check(input string name, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic refresh(input int i);
      rw_a[i]   = 1'($urandom);
      be_a[i]   = 4'($urandom);
      addr_a[i] = $urandom;
      data_a[i] = $urandom;
      tag_a[i]  = 8'($urandom);
   endtask

   // One clock of the N=4 DUT, entered and left at the falling edge.
   task automatic cycle();
      int   w;
      bit   se;
      logic [3:0] exp_rdy;
      tx_t  t;
      #1;
      se = (q.size() == 0) || ready_in;
      w  = -1;
      for (int k = 0; k < 4; k++)
         if (w < 0 && valid_in[(mptr + k) % 4]) w = (mptr + k) % 4;
      exp_rdy = (rst_n && se && w >= 0) ? (4'b0001 << w) : 4'b0000;
      check("ready_out", 80'(ready_out), 80'(exp_rdy));
      if (!rst_n) begin
         q.delete();
         mptr = 0;
         w = -1;
      end else begin
         if (q.size() != 0 && ready_in) void'(q.pop_front());
         if (se && w >= 0) begin
            t = '{rw: rw_a[w], be: be_a[w], addr: addr_a[w], data: data_a[w],
                  tag: {tag_a[w], 2'(w)}};
            q.push_back(t);
            mptr = (w + 1) % 4;
         end else begin
            w = -1;
         end
      end
      @(posedge clk);
      #1;
      check("valid_out", 80'(valid_out), 80'(q.size() != 0));
      if (q.size() != 0)
         check("payload", 80'({rw_out, be_out, addr_out, data_out, tag_out}), 80'(q[0]));
      if (w >= 0) refresh(w);
      @(negedge clk);
   endtask

   initial begin
      int seq2 [5] = '{0, 1, 2, 3, 0};
      logic [9:0] seq5 [4] = '{10'h040, 10'h04A, 10'h040, 10'h04A};
      logic [2:0] rdy5 [4] = '{3'b001, 3'b100, 3'b001, 3'b100};
      for (int i = 0; i < 4; i++) refresh(i);
      rst_n = 1'b0; valid_in = 4'hF; ready_in = 1'b1;
      valid3 = 3'b000; ready3_in = 1'b1;

      // Reset with every input requesting.
      cycle(); cycle();
      rst_n = 1'b1;

      // All inputs valid, sink always ready: strict rotation from pointer 0.
      for (int k = 0; k < 5; k++) begin
         cycle();
         check("t2_sel", 80'(tag_out[1:0]), 80'(seq2[k]));
      end

      // Random traffic and backpressure.
      for (int k = 0; k < 40; k++) begin
         valid_in = 4'($urandom);
         ready_in = 1'($urandom);
         cycle();
      end

      // Single requester on input 2.
      ready_in = 1'b1; valid_in = 4'b0100;
      addr_a[2] = 32'h1000; tag_a[2] = 8'h5A;
      cycle();
      check("t3_addr", 80'(addr_out), 80'(32'h1000));
      check("t3_tag", 80'(tag_out), 80'(10'h16A));

      // Five cycles of backpressure with all inputs requesting.
      ready_in = 1'b0; valid_in = 4'hF;
      for (int k = 0; k < 5; k++) cycle();
      check("t4_addr_held", 80'(addr_out), 80'(32'h1000));
      ready_in = 1'b1;
      cycle(); cycle();

      // Reset while a request is stalled at the output.
      valid_in = 4'b0001; ready_in = 1'b1;
      cycle();
      ready_in = 1'b0; rst_n = 1'b0;
      cycle();
      check("t6_valid_cleared", 80'(valid_out), 80'(1'b0));
      rst_n = 1'b1; valid_in = 4'b0000;
      cycle();

      // Three-input instance, inputs 0 and 2 continuously valid.
      valid3 = 3'b101; ready3_in = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("t5_ready", 80'(ready3_out), 80'(rdy5[k]));
         @(posedge clk);
         #1;
         check("t5_valid", 80'(valid3_out), 80'(1'b1));
         check("t5_tag", 80'(tag3_out), 80'(seq5[k]));
         check("t5_ptr_lt3", 80'(dut3.u_arb.ptr_reg < 2'd3), 80'(1'b1));
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
